bus_grant_scheduler: RTL and testbench
======================================

# bus_grant_scheduler

Bus-ownership scheduler for the two-master serial system bus. It sits between the master ports (breq/bgrant/split) and the bus multiplexers, and decides which master drives the bus. It arbitrates round-robin, parks a master whose transaction the split-capable slave has split, re-grants that master with priority when the slave resumes, and revokes a grant held longer than a watchdog limit.

## Interface
Parameters:
- TIMEOUT, 64: maximum consecutive grant cycles per tenure; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- m1_breq  in  1  master 1 bus request, level; held high for the whole transaction, including while split.
- m2_breq  in  1  master 2 bus request, level.
- slave_split  in  1  from the split-capable slave. Rising edge means the current transaction is split. Low again means the slave is ready to resume.
- m1_bgrant  out  1  master 1 owns the bus.
- m2_bgrant  out  1  master 2 owns the bus.
- m1_split  out  1  master 1 is parked by a split.
- m2_split  out  1  master 2 is parked by a split.
- owner  out  2  bus mux select: 0 none, 1 M1, 2 M2 (3 never driven).
- timeout_err  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner holds bgrant.
  - TURN: one dead cycle after any release.
- Registers:
  - last_owner: reset M2, so M1 wins the first tie.
  - split_pending: none/M1/M2.
  - slave_split_q: for edge detect.
  - grant counter.
- IDLE arbitration uses eligible requests only. A master with split_pending set is ineligible while its mX_split is high. Priority order:
  - a resumed split master (split_pending set, slave_split low);
  - otherwise the single eligible requester;
  - otherwise, with both eligible, the master that is not last_owner.
- IDLE→BUSY: set bgrant and owner; last_owner ← winner; clear counter.
- BUSY→TURN on either of:
  - the owner's breq low (normal release);
  - watchdog expiry: counter == TIMEOUT-1 with breq still high. This pulses timeout_err and does not set split.
- BUSY→TURN on a split rise (slave_split high and slave_split_q low):
  - drop the owner's bgrant;
  - assert mX_split;
  - split_pending ← owner.
- TURN→IDLE always.
- A split rise is ignored in IDLE/TURN and while split_pending is already set (single split slave).
- slave_split low with split_pending set: clear mX_split on the next edge. That master wins the next IDLE arbitration regardless of round-robin. split_pending clears when it is granted.
- If the parked master drops breq while split, clear split_pending and mX_split; it returns to normal arbitration.
- Simultaneous events:
  - A split rise beats a breq drop and beats watchdog expiry in the same cycle. Split is recorded; no timeout_err.
  - Resume and a new request in the same cycle: the resumed master wins.
- Reset (asynchronous, any time):
  - all outputs 0, owner 0;
  - state IDLE;
  - split_pending none;
  - last_owner M2;
  - counter 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Grant latency: breq high sampled at edge N in IDLE gives bgrant high after edge N.
- Release: breq low sampled at edge N drops bgrant after edge N. The next grant is visible no earlier than after edge N+2 (one TURN cycle).
- Split: a slave_split rise sampled at edge N gives bgrant low and mX_split high after edge N.
- Resume: slave_split low sampled at edge N gives mX_split low after edge N. The grant follows at the next IDLE edge.
- Watchdog: bgrant is high for exactly TIMEOUT cycles, then drops. timeout_err is high for the first cycle bgrant is low.
- owner changes on the same edge as bgrant. m1_bgrant and m2_bgrant are never both high.

## Structure
- Shared package bus_sched_pkg holds:
  - state enum {IDLE, BUSY, TURN};
  - owner enum {OWN_NONE=0, OWN_M1=1, OWN_M2=2}, reused by the bus mux select.
- Sub-module grant_watchdog (parameter TIMEOUT):
  - counter of width $clog2(TIMEOUT+1);
  - inputs clk, rstn, clear, enable;
  - output expire;
  - tied off when TIMEOUT=0.

## Test plan
- Reset, then m2_breq high alone: m2_bgrant=1 one cycle later, owner=2. Drop breq: bgrant low, then one dead cycle.
- m1_breq and m2_breq rise together twice in succession: first M1 granted, then M2, then M1 (round-robin). Never both grants high.
- M1 granted, slave_split pulses high: m1_bgrant=0, m1_split=1. M2 is granted meanwhile while M1 holds breq high. slave_split low: m1_split=0. After M2 releases, M1 is granted ahead of a pending M2 re-request.
- TIMEOUT=8, M1 holds breq forever: m1_bgrant high exactly 8 cycles, timeout_err one pulse, then M2 granted if requesting.
- Split rise, owner breq drop and watchdog expiry in the same cycle: split recorded, timeout_err stays 0.
- rstn low mid-split with M2 owning: all outputs 0 immediately, split state cleared. After release, M1 wins the first tie.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types for the bus grant scheduler: FSM states and bus-owner encoding.
package bus_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } state_e;

   // Doubles as the bus mux select; encoding 3 is never produced.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M1   = 2'd1,
      OWN_M2   = 2'd2
   } owner_e;

endpackage

// File: rtl/grant_watchdog.sv
// Tenure watchdog: counts cycles of an active grant and flags the last allowed one.
module grant_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   generate
      if (TIMEOUT == 0) begin : g_off
         // Watchdog disabled: never expires; inputs intentionally ignored.
         logic w_unused;
         assign w_unused = clk ^ rstn ^ clear ^ enable;
         assign expire   = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] r_cnt;

         // Count grant cycles; a new tenure restarts from zero.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       r_cnt <= '0;
            else if (clear)  r_cnt <= '0;
            else if (enable) r_cnt <= r_cnt + 1'b1;
         end

         // Counter value TIMEOUT-1 marks the final permitted grant cycle.
         assign expire = enable && (r_cnt == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/bus_grant_scheduler.sv
// Two-master bus ownership scheduler: round-robin arbitration, split parking
// with priority resume, and watchdog revocation of over-long tenures.
module bus_grant_scheduler
   import bus_sched_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       m1_breq,
   input  logic       m2_breq,
   input  logic       slave_split,
   output logic       m1_bgrant,
   output logic       m2_bgrant,
   output logic       m1_split,
   output logic       m2_split,
   output logic [1:0] owner,
   output logic       timeout_err
);

   state_e r_state, w_state_nxt;
   owner_e r_owner, w_owner_nxt;
   owner_e r_last,  w_last_nxt;
   owner_e r_pend,  w_pend_nxt;
   owner_e w_win;
   logic   r_m1_split, w_m1_split_nxt;
   logic   r_m2_split, w_m2_split_nxt;
   logic   r_split_q;
   logic   r_tmo, w_tmo_nxt;

   logic   w_split_rise;
   logic   w_own_breq;
   logic   w_m1_elig, w_m2_elig;
   logic   w_wd_clear, w_wd_en, w_expire;

   assign w_split_rise = slave_split && !r_split_q;
   assign w_own_breq   = (r_owner == OWN_M1) ? m1_breq : m2_breq;

   // A parked master stays out of arbitration until its split flag drops.
   assign w_m1_elig = m1_breq && !((r_pend == OWN_M1) && r_m1_split);
   assign w_m2_elig = m2_breq && !((r_pend == OWN_M2) && r_m2_split);

   assign w_wd_clear = (r_state == IDLE) && (w_win != OWN_NONE);
   assign w_wd_en    = (r_state == BUSY);

   grant_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (w_wd_clear),
      .enable (w_wd_en),
      .expire (w_expire)
   );

   // Next-state, arbitration and split bookkeeping.
   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_last_nxt     = r_last;
      w_pend_nxt     = r_pend;
      w_m1_split_nxt = r_m1_split;
      w_m2_split_nxt = r_m2_split;
      w_tmo_nxt      = 1'b0;
      w_win          = OWN_NONE;

      // Slave ready again: release the parked master's split flag.
      if (!slave_split) begin
         if (r_pend == OWN_M1) w_m1_split_nxt = 1'b0;
         if (r_pend == OWN_M2) w_m2_split_nxt = 1'b0;
      end
      // Parked master gave up its request: forget the split entirely.
      if ((r_pend == OWN_M1) && !m1_breq) begin
         w_pend_nxt     = OWN_NONE;
         w_m1_split_nxt = 1'b0;
      end
      if ((r_pend == OWN_M2) && !m2_breq) begin
         w_pend_nxt     = OWN_NONE;
         w_m2_split_nxt = 1'b0;
      end

      case (r_state)
         IDLE: begin
            if ((r_pend == OWN_M1) && !r_m1_split && m1_breq)      w_win = OWN_M1;
            else if ((r_pend == OWN_M2) && !r_m2_split && m2_breq) w_win = OWN_M2;
            else if (w_m1_elig && !w_m2_elig)                      w_win = OWN_M1;
            else if (w_m2_elig && !w_m1_elig)                      w_win = OWN_M2;
            else if (w_m1_elig && w_m2_elig)
               w_win = (r_last == OWN_M1) ? OWN_M2 : OWN_M1;

            if (w_win != OWN_NONE) begin
               w_state_nxt = BUSY;
               w_owner_nxt = w_win;
               w_last_nxt  = w_win;
               if (r_pend == w_win) w_pend_nxt = OWN_NONE;
            end
         end
         BUSY: begin
            // Split wins over release and watchdog in the same cycle.
            if (w_split_rise && (r_pend == OWN_NONE)) begin
               w_state_nxt = TURN;
               w_owner_nxt = OWN_NONE;
               w_pend_nxt  = r_owner;
               if (r_owner == OWN_M1) w_m1_split_nxt = 1'b1;
               if (r_owner == OWN_M2) w_m2_split_nxt = 1'b1;
            end else if (!w_own_breq) begin
               w_state_nxt = TURN;
               w_owner_nxt = OWN_NONE;
            end else if (w_expire) begin
               w_state_nxt = TURN;
               w_owner_nxt = OWN_NONE;
               w_tmo_nxt   = 1'b1;
            end
         end
         TURN:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_owner    <= OWN_NONE;
         r_last     <= OWN_M2;
         r_pend     <= OWN_NONE;
         r_m1_split <= 1'b0;
         r_m2_split <= 1'b0;
         r_split_q  <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_last     <= w_last_nxt;
         r_pend     <= w_pend_nxt;
         r_m1_split <= w_m1_split_nxt;
         r_m2_split <= w_m2_split_nxt;
         r_split_q  <= slave_split;
         r_tmo      <= w_tmo_nxt;
      end
   end

   // Grants decode the owner register, so they move together and never overlap.
   assign m1_bgrant   = (r_owner == OWN_M1);
   assign m2_bgrant   = (r_owner == OWN_M2);
   assign owner       = r_owner;
   assign m1_split    = r_m1_split;
   assign m2_split    = r_m2_split;
   assign timeout_err = r_tmo;

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Directed-vector bench for bus_grant_scheduler (TIMEOUT=8) with a queue scoreboard.
module tb_bus_grant_scheduler;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       m1_breq = 1'b0, m2_breq = 1'b0, slave_split = 1'b0;
   logic       m1_bgrant, m2_bgrant, m1_split, m2_split, timeout_err;
   logic [1:0] owner;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         idx;
      logic       g1, g2, s1, s2;
      logic [1:0] own;
      logic       tmo;
   } exp_t;

   typedef struct {
      logic       rp, b1, b2, ss;
      logic       g1, g2, s1, s2;
      logic [1:0] own;
      logic       tmo;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];

   bus_grant_scheduler #(.TIMEOUT(8)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .m1_breq     (m1_breq),
      .m2_breq     (m2_breq),
      .slave_split (slave_split),
      .m1_bgrant   (m1_bgrant),
      .m2_bgrant   (m2_bgrant),
      .m1_split    (m1_split),
      .m2_split    (m2_split),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // One row: inputs applied before an edge, outputs expected after it.
   task automatic v(input logic rp, b1, b2, ss, g1, g2, s1, s2,
                    input logic [1:0] own, input logic tmo);
      vec_t t;
      t.rp = rp; t.b1 = b1; t.b2 = b2; t.ss = ss;
      t.g1 = g1; t.g2 = g2; t.s1 = s1; t.s2 = s2; t.own = own; t.tmo = tmo;
      vecs.push_back(t);
   endtask

   // Monitor: compare DUT outputs against the oldest expectation each cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if ({m1_bgrant, m2_bgrant, m1_split, m2_split, owner, timeout_err} !==
             {e.g1, e.g2, e.s1, e.s2, e.own, e.tmo}) begin
            n_bad++;
            $display("FAIL row%0d outs: got g1=%b g2=%b s1=%b s2=%b own=%0d tmo=%b, want g1=%b g2=%b s1=%b s2=%b own=%0d tmo=%b",
                     e.idx, m1_bgrant, m2_bgrant, m1_split, m2_split, owner, timeout_err,
                     e.g1, e.g2, e.s1, e.s2, e.own, e.tmo);
         end
         n_cmp++;
         if ((m1_bgrant && m2_bgrant) || (owner == 2'd3)) begin
            n_bad++;
            $display("FAIL row%0d exclusive: got g1=%b g2=%b own=%0d, want at most one grant and own!=3",
                     e.idx, m1_bgrant, m2_bgrant, owner);
         end
      end
   end

   initial begin
      // reset, then M2 alone, release, dead cycle
      v(1,0,0,0, 0,0,0,0,0,0);
      v(0,0,1,0, 0,1,0,0,2,0);
      v(0,0,1,0, 0,1,0,0,2,0);
      v(0,0,0,0, 0,0,0,0,0,0);
      v(0,1,1,0, 0,0,0,0,0,0);
      // round-robin on simultaneous requests: M1, M2, M1
      v(0,1,1,0, 1,0,0,0,1,0);
      v(0,0,1,0, 0,0,0,0,0,0);
      v(0,1,1,0, 0,0,0,0,0,0);
      v(0,1,1,0, 0,1,0,0,2,0);
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,1,0, 1,0,0,0,1,0);
      // split M1, M2 served meanwhile, resume, M1 regranted first
      v(0,1,1,1, 0,0,1,0,0,0);
      v(0,1,1,1, 0,0,1,0,0,0);
      v(0,1,1,1, 0,1,1,0,2,0);
      v(0,1,1,1, 0,1,1,0,2,0);
      v(0,1,1,0, 0,1,0,0,2,0);
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,1,0, 0,0,0,0,0,0);
      v(0,1,1,0, 1,0,0,0,1,0);
      // split rise + breq drop + watchdog expiry together
      for (int i = 0; i < 7; i++) v(0,1,0,0, 1,0,0,0,1,0);
      v(0,0,0,1, 0,0,1,0,0,0);
      v(0,0,0,1, 0,0,0,0,0,0);
      v(0,0,0,0, 0,0,0,0,0,0);
      // watchdog: 8 grant cycles, one timeout pulse, then M2
      v(0,1,0,0, 1,0,0,0,1,0);
      for (int i = 0; i < 7; i++) v(0,1,1,0, 1,0,0,0,1,0);
      v(0,1,1,0, 0,0,0,0,0,1);
      v(0,1,1,0, 0,0,0,0,0,0);
      v(0,1,1,0, 0,1,0,0,2,0);
      // M1 split, M2 owns, asynchronous reset, M1 wins first tie
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,0,0, 1,0,0,0,1,0);
      v(0,1,1,1, 0,0,1,0,0,0);
      v(0,1,1,1, 0,0,1,0,0,0);
      v(0,1,1,1, 0,1,1,0,2,0);
      v(1,1,1,1, 1,0,0,0,1,0);
      v(0,1,1,1, 1,0,0,0,1,0);
      v(0,0,1,0, 0,0,0,0,0,0);
      // resumed master beats round-robin
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,0,0, 1,0,0,0,1,0);
      v(0,1,0,1, 0,0,1,0,0,0);
      v(0,1,0,0, 0,0,0,0,0,0);
      v(0,1,1,0, 1,0,0,0,1,0);
      v(0,0,1,0, 0,0,0,0,0,0);
      v(0,0,0,0, 0,0,0,0,0,0);

      foreach (vecs[k]) begin
         exp_t e;
         @(negedge clk);
         #1;
         m1_breq     = vecs[k].b1;
         m2_breq     = vecs[k].b2;
         slave_split = vecs[k].ss;
         if (vecs[k].rp) begin
            rstn = 1'b0;
            #2;
         end
         rstn = 1'b1;
         e.idx = k; e.g1 = vecs[k].g1; e.g2 = vecs[k].g2; e.s1 = vecs[k].s1;
         e.s2 = vecs[k].s2; e.own = vecs[k].own; e.tmo = vecs[k].tmo;
         exp_q.push_back(e);
      end

      repeat (3) @(negedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked rows, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
